// File: rtl/m_if_fetch.sv
// Instruction-fetch stage: drives a request/response instruction memory and holds one fetched
// word for the IF/ID register. Define FETCH_TRACE_EN to print each instruction at handover.
module m_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  output logic [2:0]  dbg_state
);

  // Memory handshake: a request is accepted on a cycle where imem_req and imem_ready are both 1;
  // exactly one imem_rvalid pulse follows each accepted request, and imem_rdata is sampled only then.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (pcsrcD) begin
      // Redirect beats stall everywhere; a request already accepted must have its response drained.
      pc_d    = {pcbranchD[31:2], 2'b00};
      instr_d = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
      case (state_q)
        S_REQ:   state_d = imem_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stallF) begin
            pc_d    = pc_plus4;
            instr_d = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && !pcsrcD && !stallF && state_q == S_HOLD)
      $display("Instruction %h is in IF stage", instr_q);
  end
`endif

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pcplus4     = pcp4_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/m_if_fetch.md
M_IF_FETCH -- requirements
Module: m_if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stallF  input  1  hazard-unit stall; 1 = hold current instruction, do not advance PC.
REQ-005 pcsrcD  input  1  branch/jump taken in ID; redirect fetch and kill current fetch.
REQ-006 pcbranchD  input  32  redirect target.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  request address, equal to pcF.
REQ-009 imem_ready  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  response data valid.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 instr  output  32  fetched instruction to IF/ID register.
REQ-013 pcplus4  output  32  address of instr plus 4.
REQ-014 instr_valid  output  1  instr/pcplus4 hold a live instruction.

Function
REQ-015 pcF SHALL be a 32-bit register with pcF[1:0] always 2'b00; pcbranchD[1:0] SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; all outputs registered except imem_req/imem_addr, decoded from state/pcF.
REQ-017 IDLE: imem_req=0; SHALL go to REQ next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pcF; on imem_ready=1 go to WAIT, else stay.
REQ-019 WAIT: imem_req=0; on imem_rvalid=1 load instr<=imem_rdata, pcplus4<=pcF+4, instr_valid<=1, go to HOLD.
REQ-020 HOLD: instr/pcplus4/instr_valid held; handover occurs on a cycle with stallF=0 and pcsrcD=0, then pcF<=pcF+4, instr<=0, pcplus4<=0, instr_valid<=0, go to REQ.
REQ-021 HOLD with stallF=1 SHALL retain all state indefinitely.
REQ-022 When instr_valid=0, instr and pcplus4 SHALL be 0 (bubble, matching IF/ID flush value).
REQ-023 pcsrcD=1 SHALL take priority over stallF in every state: pcF<=pcbranchD, instr<=0, pcplus4<=0, instr_valid<=0.
REQ-024 pcsrcD=1 in WAIT, or in REQ with imem_ready=1 the same cycle, SHALL go to DRAIN; in IDLE, REQ (not accepted) or HOLD SHALL go to REQ.
REQ-025 DRAIN: imem_req=0; the next imem_rvalid SHALL be discarded, then go to REQ; a further pcsrcD=1 in DRAIN updates pcF and stays in DRAIN.
REQ-026 pcsrcD=1 coincident with imem_rvalid=1 in WAIT SHALL discard the response and go to REQ (not DRAIN).
REQ-027 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored with no state change.
REQ-028 pcF+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 Minimum throughput: one instruction per 3 cycles with imem_ready=1 and one-cycle response.

Reset
REQ-030 reset=1 SHALL set pcF=RESET_PC, state=IDLE, instr=0, pcplus4=0, instr_valid=0, imem_req=0, overriding pcsrcD and stallF.
REQ-031 Reset asserted mid-request SHALL abandon the outstanding transaction; a stale imem_rvalid arriving in IDLE is ignored per REQ-027.

Configuration
REQ-032 Macro FETCH_TRACE_EN: when defined, each handover (REQ-020) SHALL $display "Instruction %h is in IF stage" with instr; when undefined, no display code exists; datapath behaviour SHALL be identical either way.

Verification
REQ-033 Reset, RESET_PC=0, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h2002_0005, stallF=0 -> imem_addr=0 in REQ; instr=32'h2002_0005, pcplus4=4, instr_valid=1; next request addr=4.
REQ-034 HOLD with stallF=1 for 5 cycles -> instr, pcplus4, instr_valid unchanged, imem_req=0; on stallF=0 next request addr=pcF+4.
REQ-035 pcsrcD=1, pcbranchD=32'h0000_0040 while in WAIT -> instr_valid=0, instr=0; next rvalid discarded; next imem_addr=32'h40.
REQ-036 pcsrcD=1 and stallF=1 together in HOLD -> redirect wins, pcF=pcbranchD, instr_valid=0, next state REQ.
REQ-037 pcF=32'hFFFF_FFFC, fetch and handover -> pcplus4=0, next imem_addr=0.
REQ-038 reset asserted in WAIT, rvalid arrives next cycle -> ignored, instr_valid=0, first request addr=RESET_PC two cycles after reset deasserts.
